// File: rtl/dht11_responder.sv
// dht11_responder -- DHT11 sensor emulator on an open-drain single-wire bus.
//
// Waits for a host start pulse (a long low), answers with the DHT11 response
// preamble, and then sends 40 bits. The bytes are humid_int, humid_dec,
// temp_int, temp_dec and an 8-bit checksum, each MSB first. A '0' bit is a
// 50 us low followed by a 26 us high. A '1' bit is a 50 us low followed by a
// 70 us high.
//
// Ports:
//   clk_50mhz    in   system clock, rising edge
//   reset        in   synchronous, active low
//   dht_data_in  in   sampled bus level (asynchronous, synchronized here)
//   dht_data_oe  out  1 = pull bus low, 0 = release
//   humid_int/humid_dec/temp_int/temp_dec  in  [7:0] payload bytes,
//                     captured when the start pulse is accepted
//   busy         out  high from start acceptance until frame end
//   frame_done   out  one-cycle pulse when the bus is released after a frame
//   start_err    out  one-cycle pulse when the host low pulse is too short
//
// Build option: define DHT11_RESP_GLITCH_FILTER_EN to require 4 consecutive
// identical synchronized samples before the internal bus level changes.
module dht11_responder #(
    parameter int CLK_PER_US   = 50,
    parameter int START_MIN_US = 18000
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       dht_data_in,
    output logic       dht_data_oe,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done,
    output logic       start_err
);

    localparam int              PW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(CLK_PER_US - 1);
    localparam logic [14:0]     START_MIN = 15'(START_MIN_US);
    localparam logic [14:0]     US_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE, HOST_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q;
    logic          bus, bus_prev_q;
    logic [PW-1:0] pre_q;
    logic [14:0]   us_q;
    logic [5:0]    bit_cnt_q;
    logic [39:0]   shreg_q;
    logic          oe_q, busy_q, frame_done_q, start_err_q;
    logic          tick, fall, rise, phase_done;
    logic [14:0]   phase_last;
    logic [7:0]    checksum;

    // Two-flop synchronizer. It resets to 1 (idle bus) so that reset does not
    // create a false falling edge.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= dht_data_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef DHT11_RESP_GLITCH_FILTER_EN
    logic       filt_q;
    logic [1:0] filt_cnt_q;

    // The filter output flips on the 4th consecutive sample that differs
    // from it. Any agreeing sample restarts the count.
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (sync2_q == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == 2'd3) begin
            filt_q     <= sync2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 2'd1;
        end
    end

    assign bus = filt_q;
`else
    assign bus = sync2_q;
`endif

    // bus_prev_q tracks the bus in every state. A bus that is still low after
    // END_LOW therefore never looks like a fresh falling edge.
    assign fall = bus_prev_q & ~bus;
    assign rise = ~bus_prev_q & bus;
    assign tick = (pre_q == PRE_LAST);

    assign checksum = humid_int + humid_dec + temp_int + temp_dec;

    // Last microsecond index of the current timed phase. A phase ends on the
    // tick that completes it, so each phase lasts exactly N*CLK_PER_US cycles.
    always_comb begin
        phase_last = '0;
        case (state_q)
            RESP_DELAY:         phase_last = 15'd29;
            RESP_LOW,
            RESP_HIGH:          phase_last = 15'd79;
            BIT_LOW, END_LOW:   phase_last = 15'd49;
            BIT_HIGH:           phase_last = shreg_q[39] ? 15'd69 : 15'd25;
            default:            phase_last = '0;
        endcase
    end

    assign phase_done = tick && (us_q == phase_last);

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state_q      <= IDLE;
            bus_prev_q   <= 1'b1;
            pre_q        <= '0;
            us_q         <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            oe_q         <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
            bus_prev_q   <= bus;

            // Free-running interval timer. Every transition below restarts it.
            // The us count saturates, so a very long host pulse never wraps.
            if (tick) begin
                pre_q <= '0;
                if (us_q != US_MAX) us_q <= us_q + 15'd1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= HOST_LOW;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                HOST_LOW: begin
                    if (rise) begin
                        pre_q <= '0;
                        us_q  <= '0;
                        if (us_q >= START_MIN) begin
                            state_q <= RESP_DELAY;
                            busy_q  <= 1'b1;
                            shreg_q <= {humid_int, humid_dec, temp_int, temp_dec, checksum};
                        end else begin
                            state_q     <= IDLE;
                            start_err_q <= 1'b1;
                        end
                    end
                end
                RESP_DELAY: begin
                    if (phase_done) begin
                        state_q <= RESP_LOW;
                        oe_q    <= 1'b1;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                RESP_LOW: begin
                    if (phase_done) begin
                        state_q <= RESP_HIGH;
                        oe_q    <= 1'b0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                RESP_HIGH: begin
                    if (phase_done) begin
                        state_q   <= BIT_LOW;
                        oe_q      <= 1'b1;
                        bit_cnt_q <= '0;
                        pre_q     <= '0;
                        us_q      <= '0;
                    end
                end
                BIT_LOW: begin
                    if (phase_done) begin
                        state_q <= BIT_HIGH;
                        oe_q    <= 1'b0;
                        pre_q   <= '0;
                        us_q    <= '0;
                    end
                end
                BIT_HIGH: begin
                    if (phase_done) begin
                        oe_q  <= 1'b1;
                        pre_q <= '0;
                        us_q  <= '0;
                        if (bit_cnt_q == 6'd39) begin
                            state_q <= END_LOW;
                        end else begin
                            state_q   <= BIT_LOW;
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            shreg_q   <= {shreg_q[38:0], 1'b0};
                        end
                    end
                end
                END_LOW: begin
                    if (phase_done) begin
                        state_q      <= IDLE;
                        oe_q         <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        pre_q        <= '0;
                        us_q         <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dht_data_oe = oe_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign start_err   = start_err_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder, with CLK_PER_US=2 and START_MIN_US=100.
// The bus is modelled as a wired-AND of the host driver and the responder's
// pull-down. Frames are decoded by measuring the oe phase lengths in cycles:
// 1 us is 2 cycles.
module tb_dht11_responder;

    localparam int CPU  = 2;
    localparam int SMIN = 100;
    localparam int LIM  = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       host_drv;
    logic       dht_data_in;
    logic       oe, busy, frame_done, start_err;
    logic [7:0] hi, hd, ti, td;

    always #5 clk = ~clk;

    assign dht_data_in = host_drv & ~oe;

    dht11_responder #(.CLK_PER_US(CPU), .START_MIN_US(SMIN)) dut (
        .clk_50mhz   (clk),
        .reset       (reset),
        .dht_data_in (dht_data_in),
        .dht_data_oe (oe),
        .humid_int   (hi),
        .humid_dec   (hd),
        .temp_int    (ti),
        .temp_dec    (td),
        .busy        (busy),
        .frame_done  (frame_done),
        .start_err   (start_err)
    );

    int checks = 0, failures = 0;
    int fd_cnt = 0, se_cnt = 0, oe_cnt = 0, busy_cnt = 0;

    always @(posedge clk) begin
        if (frame_done === 1'b1) fd_cnt   <= fd_cnt + 1;
        if (start_err === 1'b1)  se_cnt   <= se_cnt + 1;
        if (oe === 1'b1)         oe_cnt   <= oe_cnt + 1;
        if (busy === 1'b1)       busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic count_while(input logic val, output int n);
        n = 0;
        while (oe === val && n < LIM) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic host_pulse(input int cyc);
        @(negedge clk);
        host_drv = 1'b0;
        repeat (cyc) @(negedge clk);
        host_drv = 1'b1;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Receive one frame. terr counts phase lengths that differ from the exact
    // cycle counts implied by exp. got is decoded from the lengths alone.
    task automatic rx_frame(input logic [39:0] exp, output logic [39:0] got,
                            output int terr, output logic fd_end, output logic busy_end);
        int n;
        got  = '0;
        terr = 0;
        wait_busy(n);
        if (n >= 20000) terr++;
        count_while(1'b0, n); if (n != 30*CPU) terr++;
        count_while(1'b1, n); if (n != 80*CPU) terr++;
        count_while(1'b0, n); if (n != 80*CPU) terr++;
        for (int i = 0; i < 40; i++) begin
            count_while(1'b1, n); if (n != 50*CPU) terr++;
            count_while(1'b0, n);
            got = {got[38:0], (n > 48*CPU)};
            if (n != (exp[39-i] ? 70*CPU : 26*CPU)) terr++;
        end
        count_while(1'b1, n); if (n != 50*CPU) terr++;
        fd_end   = frame_done;
        busy_end = busy;
    endtask

    initial begin
        logic [39:0] got;
        int          terr, n, rises, fd0, se0;
        logic        fd_end, busy_end, prev;

        reset    = 1'b0;
        host_drv = 1'b1;
        {hi, hd, ti, td} = '0;
        repeat (3) @(negedge clk);
        chk("reset_oe",    oe,         1'b0);
        chk("reset_busy",  busy,       1'b0);
        chk("reset_fd",    frame_done, 1'b0);
        chk("reset_serr",  start_err,  1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Short start pulse (60 us): rejected.
        host_pulse(60*CPU);
        repeat (20) @(negedge clk);
        chk("short_serr_cnt", se_cnt,   1);
        chk("short_oe_cnt",   oe_cnt,   0);
        chk("short_busy_cnt", busy_cnt, 0);

        // 2-cycle glitch in IDLE.
        host_pulse(2);
        repeat (20) @(negedge clk);
`ifdef DHT11_RESP_GLITCH_FILTER_EN
        chk("glitch_serr_cnt", se_cnt, 1);
`else
        chk("glitch_serr_cnt", se_cnt, 2);
`endif
        chk("glitch_busy_cnt", busy_cnt, 0);

        // Nominal frame.
        {hi, hd, ti, td} = {8'h37, 8'h00, 8'h19, 8'h05};
        fd0 = fd_cnt; se0 = se_cnt;
        host_pulse(120*CPU);
        rx_frame(40'h3700190555, got, terr, fd_end, busy_end);
        chk("f1_data",   got,      40'h3700190555);
        chk("f1_timing", terr,     0);
        chk("f1_fd_end", fd_end,   1'b1);
        chk("f1_busy",   busy_end, 1'b0);
        repeat (10) @(negedge clk);
        chk("f1_fd_cnt", fd_cnt,   fd0 + 1);
        chk("f1_serr",   se_cnt,   se0);

        // All-ones payload: checksum 0xFC.
        {hi, hd, ti, td} = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        host_pulse(120*CPU);
        rx_frame(40'hFFFFFFFFFC, got, terr, fd_end, busy_end);
        chk("f2_data",   got,      40'hFFFFFFFFFC);
        chk("f2_cksum",  got[7:0], 8'hFC);
        chk("f2_timing", terr,     0);
        repeat (10) @(negedge clk);

        // Inputs cleared during RESP_HIGH: the latched frame is still sent.
        {hi, hd, ti, td} = {8'h12, 8'h34, 8'h56, 8'h78};
        host_pulse(120*CPU);
        fork
            rx_frame(40'h1234567814, got, terr, fd_end, busy_end);
            begin
                wait_busy(n);
                repeat (150*CPU) @(negedge clk);
                {hi, hd, ti, td} = '0;
            end
        join
        chk("f3_data",   got,  40'h1234567814);
        chk("f3_timing", terr, 0);
        repeat (10) @(negedge clk);

        // Reset during bit 12 low. Rise 1 is RESP_LOW, rise 14 is bit 12.
        {hi, hd, ti, td} = {8'h37, 8'h00, 8'h19, 8'h05};
        fd0 = fd_cnt;
        host_pulse(120*CPU);
        rises = 0; n = 0; prev = oe;
        while (rises < 14 && n < 20000) begin
            @(negedge clk);
            if (oe === 1'b1 && prev !== 1'b1) rises++;
            prev = oe;
            n++;
        end
        chk("rst_bit12_reached", rises, 14);
        repeat (5) @(negedge clk);
        chk("rst_pre_oe", oe, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_oe",   oe,   1'b0);
        chk("rst_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_fd", fd_cnt, fd0);
        host_pulse(120*CPU);
        rx_frame(40'h3700190555, got, terr, fd_end, busy_end);
        chk("f4_data",   got,    40'h3700190555);
        chk("f4_timing", terr,   0);
        chk("f4_fd_end", fd_end, 1'b1);
        repeat (10) @(negedge clk);
        chk("f4_fd_cnt", fd_cnt, fd0 + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
